// File: rtl/piezo_sound_arbiter.sv
// Fixed-priority arbiter for the shared PIEZO pin: picks one of five sound sources,
// runs its on/off pattern on the 1 ms tick and generates the square wave.

module piezo_blink_pattern #(
    parameter int ON_MS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_ms,
    input  logic req,
    output logic off_phase
);

    logic        req_q;
    logic [15:0] ms_cnt;

    // A rising request restarts the on-phase; that cycle's tick is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= 1'b0;
            ms_cnt    <= '0;
            off_phase <= 1'b0;
        end else begin
            req_q <= req;
            if (req && !req_q) begin
                ms_cnt    <= '0;
                off_phase <= 1'b0;
            end else if (req && tick_ms) begin
                if (ms_cnt == 16'(ON_MS - 1)) begin
                    ms_cnt    <= '0;
                    off_phase <= ~off_phase;
                end else begin
                    ms_cnt <= ms_cnt + 16'd1;
                end
            end
        end
    end

endmodule

module piezo_sound_arbiter #(
    parameter int HORN_HP       = 25000,
    parameter int ESS_HP        = 12500,
    parameter int REV_HP        = 31250,
    parameter int TURN_HP       = 50000,
    parameter int ESS_ON_MS     = 100,
    parameter int REV_ON_MS     = 500,
    parameter int CLICK_MS      = 20,
    parameter int ENG_HP_MAX    = 62500,
    parameter int ENG_HP_MIN    = 10000,
    parameter int ENG_RPM_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        mute,
    input  logic        engine_on,
    input  logic [13:0] rpm,
    input  logic        req_horn,
    input  logic        req_ess,
    input  logic        req_reverse,
    input  logic        req_turn,
    output logic [4:0]  grant,
    output logic [15:0] tone_hp,
    output logic        piezo_out
);

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_HORN,
        SRC_ESS,
        SRC_REV,
        SRC_TURN,
        SRC_ENG
    } src_e;

    src_e        win;
    logic [4:0]  win_grant;
    logic [15:0] win_hp;
    logic        win_off;
    logic        gate;

    logic        ess_off;
    logic        rev_off;

    logic        turn_q;
    logic        turn_rise;
    logic        turn_start;
    logic        click_pending;
    logic        click_act;
    logic [15:0] click_cnt;

    logic [17:0] eng_shift;
    logic [17:0] eng_diff;
    logic [15:0] eng_hp;

    logic [15:0] tone_cnt;
    logic [15:0] cnt_nxt;
    logic        tone_ph;
    logic        ph_nxt;

    piezo_blink_pattern #(.ON_MS(ESS_ON_MS)) u_ess_pat (
        .clk       (clk),
        .rst       (rst),
        .tick_ms   (tick_ms),
        .req       (req_ess),
        .off_phase (ess_off)
    );

    piezo_blink_pattern #(.ON_MS(REV_ON_MS)) u_rev_pat (
        .clk       (clk),
        .rst       (rst),
        .tick_ms   (tick_ms),
        .req       (req_reverse),
        .off_phase (rev_off)
    );

    // Engine pitch rises with rpm; 18-bit math so an oversized rpm is caught as underflow.
    always_comb begin
        eng_shift = 18'(rpm) << ENG_RPM_SHIFT;
        eng_diff  = 18'(ENG_HP_MAX) - eng_shift;
        if (eng_shift > 18'(ENG_HP_MAX) || eng_diff < 18'(ENG_HP_MIN))
            eng_hp = 16'(ENG_HP_MIN);
        else
            eng_hp = eng_diff[15:0];
    end

    always_comb begin
        win = SRC_NONE;
        if (req_horn)
            win = SRC_HORN;
        else if (req_ess)
            win = SRC_ESS;
        else if (req_reverse)
            win = SRC_REV;
        else if (click_pending || click_act)
            win = SRC_TURN;
        else if (engine_on && rpm != 14'd0)
            win = SRC_ENG;
    end

    always_comb begin
        win_grant = 5'b00000;
        win_hp    = 16'd0;
        win_off   = 1'b0;
        case (win)
            SRC_HORN: begin win_grant = 5'b00001; win_hp = 16'(HORN_HP); end
            SRC_ESS:  begin win_grant = 5'b00010; win_hp = 16'(ESS_HP); win_off = ess_off; end
            SRC_REV:  begin win_grant = 5'b00100; win_hp = 16'(REV_HP); win_off = rev_off; end
            SRC_TURN: begin win_grant = 5'b01000; win_hp = 16'(TURN_HP); end
            SRC_ENG:  begin win_grant = 5'b10000; win_hp = eng_hp; end
            default:  begin win_grant = 5'b00000; win_hp = 16'd0; end
        endcase
    end

    assign gate       = (win != SRC_NONE) && !mute && !win_off;
    assign turn_rise  = req_turn && !turn_q;
    assign turn_start = (win == SRC_TURN) && !click_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            turn_q        <= 1'b0;
            click_pending <= 1'b0;
            click_act     <= 1'b0;
            click_cnt     <= '0;
        end else begin
            turn_q <= req_turn;
            if (turn_rise)
                click_pending <= 1'b1;
            else if (turn_start)
                click_pending <= 1'b0;

            // Losing the grant mid-click drops the click for good.
            if (win != SRC_TURN) begin
                click_act <= 1'b0;
            end else if (turn_start) begin
                click_act <= 1'b1;
                click_cnt <= '0;
            end else if (tick_ms) begin
                if (click_cnt == 16'(CLICK_MS - 1))
                    click_act <= 1'b0;
                else
                    click_cnt <= click_cnt + 16'd1;
            end
        end
    end

    // A new owner starts from a clean phase; a mere pitch change keeps counting.
    always_comb begin
        cnt_nxt = tone_cnt + 16'd1;
        ph_nxt  = tone_ph;
        if (win_grant != grant || win_grant == 5'b00000) begin
            cnt_nxt = '0;
            ph_nxt  = 1'b0;
        end else if (tone_hp != 16'd0 && tone_cnt >= tone_hp - 16'd1) begin
            cnt_nxt = '0;
            ph_nxt  = ~tone_ph;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            tone_hp   <= '0;
            tone_cnt  <= '0;
            tone_ph   <= 1'b0;
            piezo_out <= 1'b0;
        end else begin
            grant     <= win_grant;
            tone_hp   <= win_hp;
            tone_cnt  <= cnt_nxt;
            tone_ph   <= ph_nxt;
            piezo_out <= ph_nxt && gate;
        end
    end

endmodule

// File: doc/piezo_sound_arbiter.md
Name: piezo_sound_arbiter

Overview:
- Shares the single PIEZO output among five sound requesters: horn, ESS emergency alarm, reverse beeper, turn-signal click, engine tone.
- Each cycle it picks the winning source by fixed priority, sequences that source's on/off pattern on a 1 ms tick, and drives the square wave itself.
- Sits between the vehicle/warning/turn-signal logic and the PIEZO pin, replacing ad-hoc muxing in the sound path.

Parameters:
- HORN_HP, 25000, horn half-period in clk cycles (1 kHz at 50 MHz)
- ESS_HP, 12500, ESS alarm half-period (2 kHz)
- REV_HP, 31250, reverse beep half-period (800 Hz)
- TURN_HP, 50000, turn click half-period (500 Hz)
- ESS_ON_MS, 100, ESS on-time and off-time, ms
- REV_ON_MS, 500, reverse on-time and off-time, ms
- CLICK_MS, 20, length of one turn click, ms
- ENG_HP_MAX, 62500, engine half-period at rpm 0
- ENG_HP_MIN, 10000, engine half-period floor
- ENG_RPM_SHIFT, 2, engine half-period = ENG_HP_MAX - (rpm << ENG_RPM_SHIFT)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_ms  in  1  one-clk strobe every 1 ms
- mute  in  1  forces silence; internal state keeps running
- engine_on  in  1  enables the engine-tone requester
- rpm  in  14  engine rpm
- req_horn  in  1  level request
- req_ess  in  1  level request
- req_reverse  in  1  level request
- req_turn  in  1  turn lamp state; each rising edge requests one click
- grant  out  5  one-hot {engine,turn,reverse,ess,horn} (bit0 = horn); 0 = idle
- tone_hp  out  16  half-period currently in use
- piezo_out  out  1  square-wave output

Behaviour:
- Reset: grant=0, tone_hp=0, piezo_out=0. All pattern counters cleared; click_pending=0; req_turn edge register=0.
- Priority: horn > ess > reverse > turn click > engine.
- Eligibility:
  - horn: req_horn=1.
  - ess: req_ess=1.
  - reverse: req_reverse=1.
  - turn: click_pending=1 or click in progress.
  - engine: engine_on=1 and rpm != 0.
- The winner is chosen combinationally from eligibility. grant and tone_hp are registered, so they update 1 clk after a request changes.
- Preemption: a higher-priority source takes over immediately.
  - A preempted ESS or reverse pattern keeps its phase.
  - A preempted click is abandoned. click_pending is not re-armed.
- ESS pattern:
  - Phase counter restarts at the on-phase when req_ess rises.
  - Toggles on/off every ESS_ON_MS ticks while req_ess is high.
  - Audible only in the on-phase. In the off-phase grant stays on ess and piezo_out is held 0; lower sources do not take over.
- Reverse pattern: same as ESS, using REV_ON_MS.
- Turn click:
  - A rising edge of req_turn sets click_pending.
  - When turn wins: clear pending, sound for CLICK_MS ticks, then release.
  - An edge during a click or while pending merges into a single pending click; pending never exceeds 1.
- Engine half-period:
  - hp = ENG_HP_MAX - (rpm << ENG_RPM_SHIFT), computed at 18-bit width.
  - If underflow or hp < ENG_HP_MIN, hp = ENG_HP_MIN.
  - hp is recomputed every cycle while engine holds the grant.
- Tone generator:
  - 16-bit counter. When it reaches tone_hp-1 it resets to 0 and piezo_out toggles.
  - On a grant change, counter and piezo_out reset to 0 in the same cycle that grant updates.
  - A tone_hp change without a grant change does not reset the counter. If the counter is >= the new hp, it wraps to 0 on the next clk.
- piezo_out is forced to 0 when grant=0, mute=1, or the winning pattern is in its off-phase.
- tick_ms coinciding with a request edge: the edge is handled first, so a restarted pattern's counter starts at 0 and that tick is not counted.
- rst asserted mid-sound: silence on the next clk, all state returns to reset values.

Test Plan:
- Reset, then req_horn=1 -> grant=5'b00001 and tone_hp=25000 one clk later; piezo_out toggles every 25000 clk.
- engine_on=1, rpm=4000 -> grant=5'b10000, tone_hp=46500. rpm=14000 -> tone_hp=10000 (clamp). rpm=0 -> grant=0, piezo_out=0.
- engine active, then req_ess=1 for 450 ticks -> grant=ess. Audible ticks 0-99, 200-299, 400-449; silent 100-199 and 300-399 with grant still ess. Drop req_ess -> engine regains grant, counter and piezo_out reset.
- Three req_turn rising edges inside one 20 ms click -> exactly two clicks total (current plus one merged pending), each CLICK_MS=20 ticks at tone_hp=50000.
- req_reverse held, req_horn pulsed for 30 ticks at reverse tick 100 -> horn preempts immediately. On release, reverse resumes in its on-phase at tick 130, phase not restarted.
- mute=1 with req_horn=1 -> grant=5'b00001, piezo_out stays 0. rst pulse mid-ESS -> all outputs 0 the next clk.
